// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage: funct3 encodings for loads
// and stores, the access FSM state encoding, and a helper that tells whether
// a funct3 value names a real load/store.
// ---------------------------------------------------------------------------
package mem_stage_pkg;

   // Load funct3 encodings
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store funct3 encodings
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Access FSM: IDLE drives the bus straight from the inputs, WAIT replays
   // the latched request until the memory answers.
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_t;

   function automatic logic f3_is_legal(input logic i_is_store, input logic [2:0] i_funct3);
      if (i_is_store)
         return (i_funct3 == F3_SB) || (i_funct3 == F3_SH) || (i_funct3 == F3_SW);
      else
         return (i_funct3 == F3_LB) || (i_funct3 == F3_LH) || (i_funct3 == F3_LW) ||
                (i_funct3 == F3_LBU) || (i_funct3 == F3_LHU);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Data-memory bus between the MEM stage (master) and the data memory (slave).
//   dmem_req   master->slave  access request
//   dmem_we    master->slave  1 = store, 0 = load
//   dmem_addr  master->slave  word-aligned byte address ([1:0] = 0)
//   dmem_wdata master->slave  store data, already replicated onto lanes
//   dmem_be    master->slave  byte enables
//   dmem_ready slave->master  access completes this cycle
//   dmem_rdata slave->master  load data, valid while dmem_ready = 1
// ---------------------------------------------------------------------------
interface mem_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ready, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ready, dmem_rdata
   );
endinterface

// File: rtl/mem_stage_load_extend.sv
// ---------------------------------------------------------------------------
// mem_stage_load_extend  (the Load_Extend block of the MEM stage)
// Purely combinational: picks the addressed byte/half/word out of a 32-bit
// memory word and sign- or zero-extends it according to the load funct3.
//   i_rdata    in  32  raw word from data memory
//   i_addr_lo  in  2   byte offset of the access within the word
//   i_funct3   in  3   load type
//   o_value    out 32  extended load result (0 for non-load encodings)
// ---------------------------------------------------------------------------
module mem_stage_load_extend
   import mem_stage_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_value
);

   logic [31:0] w_shifted;

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      // Bring the addressed lane down to bit 0; words are always aligned so
      // LW sees an unshifted word.
      w_shifted = i_rdata >> {i_addr_lo, 3'b000};
      o_value   = '0;
      unique case (i_funct3)
         F3_LB:   o_value = {{24{w_shifted[7]}},  w_shifted[7:0]};
         F3_LH:   o_value = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_LW:   o_value = w_shifted;
         F3_LBU:  o_value = {24'h0, w_shifted[7:0]};
         F3_LHU:  o_value = {16'h0, w_shifted[15:0]};
         default: o_value = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM pipeline stage: issues loads/stores on the data-memory bus, stalls the
// pipeline while memory is busy, flags misaligned/illegal accesses, and
// registers the writeback fields for the WB stage.
//   clk, reset               clock, synchronous active-high reset
//   valid_MEM .. rd_MEM      instruction fields from EX/MEM
//   dmem (master)            data-memory bus
//   readData, alu_result,
//   MemToReg_WB, RegWrite_WB,
//   rd_WB                    registered WB-side fields
//   stall_MEM                freeze upstream stages
//   misaligned_MEM           registered one-cycle fault pulse
// ---------------------------------------------------------------------------
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               valid_MEM,
   input  logic [31:0]        alu_result_MEM,
   input  logic [31:0]        writeData_MEM,
   input  logic [2:0]         funct3_MEM,
   input  logic               MemRead_MEM,
   input  logic               MemWrite_MEM,
   input  logic               MemToReg_MEM,
   input  logic               RegWrite_MEM,
   input  logic [4:0]         rd_MEM,
   mem_stage_if.master        dmem,
   output logic [31:0]        readData,
   output logic [31:0]        alu_result,
   output logic               MemToReg_WB,
   output logic               RegWrite_WB,
   output logic [4:0]         rd_WB,
   output logic               stall_MEM,
   output logic               misaligned_MEM
);

   state_t      r_state, w_state_nxt;

   logic        w_access, w_is_store, w_aligned, w_ok, w_go, w_fault, w_load_done;
   logic [1:0]  w_off;
   logic [3:0]  w_be;
   logic [31:0] w_wdata, w_ext;
   logic [2:0]  w_ext_f3;
   logic [1:0]  w_ext_off;

   // Request captured on IDLE->WAIT and replayed until dmem_ready
   logic        r_req_we;
   logic [31:0] r_req_addr, r_req_wdata;
   logic [3:0]  r_req_be;
   logic [2:0]  r_req_f3;
   logic [1:0]  r_req_off;

   logic [31:0] r_read_data, r_alu_result;
   logic        r_mem_to_reg, r_reg_write, r_misaligned;
   logic [4:0]  r_rd;

   // ---------------- request decode ----------------
   always_comb begin
      w_off      = alu_result_MEM[1:0];
      w_access   = valid_MEM & (MemRead_MEM | MemWrite_MEM);
      w_is_store = MemWrite_MEM;                 // read+write counts as a store
      unique case (funct3_MEM[1:0])
         2'b00:   w_aligned = 1'b1;
         2'b01:   w_aligned = ~w_off[0];
         2'b10:   w_aligned = (w_off == 2'b00);
         default: w_aligned = 1'b0;
      endcase
      w_ok    = f3_is_legal(w_is_store, funct3_MEM) & w_aligned;
      // New accesses are only accepted from IDLE; in WAIT the upstream stages
      // are frozen and the inputs describe the access already in flight.
      w_go    = (r_state == ST_IDLE) & w_access & w_ok;
      w_fault = (r_state == ST_IDLE) & w_access & ~w_ok;

      // Store lane placement: replicate the datum, enable the addressed lanes
      unique case (funct3_MEM[1:0])
         2'b00: begin
            w_be    = 4'b0001 << w_off;
            w_wdata = {4{writeData_MEM[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << w_off;
            w_wdata = {2{writeData_MEM[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = writeData_MEM;
         end
      endcase
   end

   // ---------------- bus drive and stall ----------------
   always_comb begin
      dmem.dmem_req   = 1'b0;
      dmem.dmem_we    = 1'b0;
      dmem.dmem_addr  = '0;
      dmem.dmem_wdata = '0;
      dmem.dmem_be    = '0;
      if (r_state == ST_IDLE) begin
         dmem.dmem_req   = w_go & ~reset;
         dmem.dmem_we    = w_is_store;
         dmem.dmem_addr  = {alu_result_MEM[31:2], 2'b00};
         dmem.dmem_wdata = w_wdata;
         dmem.dmem_be    = w_be;
      end else begin
         dmem.dmem_req   = ~reset;
         dmem.dmem_we    = r_req_we;
         dmem.dmem_addr  = r_req_addr;
         dmem.dmem_wdata = r_req_wdata;
         dmem.dmem_be    = r_req_be;
      end
   end

   assign stall_MEM   = ~reset & ~dmem.dmem_ready & (w_go | (r_state == ST_WAIT));
   assign w_load_done = ~reset & dmem.dmem_ready &
                        ((w_go & ~w_is_store) | ((r_state == ST_WAIT) & ~r_req_we));

   // ---------------- load extraction ----------------
   assign w_ext_f3  = (r_state == ST_WAIT) ? r_req_f3  : funct3_MEM;
   assign w_ext_off = (r_state == ST_WAIT) ? r_req_off : w_off;

   mem_stage_load_extend u_load_extend (
      .i_rdata   (dmem.dmem_rdata),
      .i_addr_lo (w_ext_off),
      .i_funct3  (w_ext_f3),
      .o_value   (w_ext)
   );

   // ---------------- FSM ----------------
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         ST_IDLE: if (w_go && !dmem.dmem_ready) w_state_nxt = ST_WAIT;
         ST_WAIT: if (dmem.dmem_ready)          w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // NOTE: the held request is pure datapath and is only meaningful in WAIT,
   // which reset leaves, so it carries no reset.
   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE && w_go && !dmem.dmem_ready) begin
         r_req_we    <= w_is_store;
         r_req_addr  <= {alu_result_MEM[31:2], 2'b00};
         r_req_wdata <= w_wdata;
         r_req_be    <= w_be;
         r_req_f3    <= funct3_MEM;
         r_req_off   <= w_off;
      end
   end

   // ---------------- WB register ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         r_read_data  <= '0;
         r_alu_result <= '0;
         r_mem_to_reg <= 1'b0;
         r_reg_write  <= 1'b0;
         r_rd         <= '0;
         r_misaligned <= 1'b0;
      end else begin
         r_misaligned <= w_fault;
         if (stall_MEM) begin
            r_mem_to_reg <= 1'b0;
            r_reg_write  <= 1'b0;
            r_rd         <= '0;
         end else begin
            r_alu_result <= alu_result_MEM;
            r_mem_to_reg <= MemToReg_MEM & valid_MEM;
            r_reg_write  <= RegWrite_MEM & valid_MEM & ~w_fault;
            r_rd         <= valid_MEM ? rd_MEM : 5'd0;
         end
         // Memory data is only trusted in the cycle it is handed over
         if (w_load_done) r_read_data <= w_ext;
      end
   end

   assign readData       = r_read_data;
   assign alu_result     = r_alu_result;
   assign MemToReg_WB    = r_mem_to_reg;
   assign RegWrite_WB    = r_reg_write;
   assign rd_WB          = r_rd;
   assign misaligned_MEM = r_misaligned;

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: MEM_Stage

Interface
REQ-001 SHALL have ports (name  direction  width  meaning): clk  in  1  single clock, rising edge; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have EX/MEM-side inputs: valid_MEM 1, alu_result_MEM 32 (address/ALU value), writeData_MEM 32 (store data), funct3_MEM 3, MemRead_MEM 1, MemWrite_MEM 1, MemToReg_MEM 1, RegWrite_MEM 1, rd_MEM 5.
REQ-003 SHALL have data-memory ports: dmem_req out 1, dmem_we out 1, dmem_addr out 32 (word-aligned, [1:0]=0), dmem_wdata out 32, dmem_be out 4, dmem_ready in 1, dmem_rdata in 32.
REQ-004 SHALL have WB-side registered outputs: readData 32, alu_result 32, MemToReg_WB 1, RegWrite_WB 1, rd_WB 5.
REQ-005 SHALL have outputs: stall_MEM 1 (freeze upstream stages), misaligned_MEM 1 (registered one-cycle fault pulse).

Function
REQ-006 Access = valid_MEM & (MemRead_MEM | MemWrite_MEM); MemRead and MemWrite both high SHALL be treated as a store.
REQ-007 FSM states IDLE, WAIT; IDLE->WAIT when an aligned access is requested and dmem_ready=0; WAIT->IDLE on dmem_ready=1.
REQ-008 In IDLE, dmem_req/we/addr/wdata/be SHALL be driven combinationally from the inputs; on IDLE->WAIT they SHALL be latched and held constant in WAIT until dmem_ready.
REQ-009 stall_MEM = (IDLE & aligned access & !dmem_ready) | (WAIT & !dmem_ready).
REQ-010 Latency: zero-wait memory -> WB outputs update on the next edge; each wait cycle adds one cycle.
REQ-011 While stall_MEM=1, the WB register SHALL load a bubble (RegWrite_WB=0, MemToReg_WB=0, rd_WB=0); other fields are don't-care.
REQ-012 When not stalled, WB register captures alu_result_MEM, MemToReg_MEM, RegWrite_MEM & valid_MEM, rd_MEM, and the extended load data.
REQ-013 Loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; lane selected by address[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
REQ-014 Stores: 000 SB be=0001<<a[1:0], data byte replicated x4; 001 SH be=0011<<a[1:0], half replicated x2; 010 SW be=1111.
REQ-015 Misaligned (half with a[0]=1, word with a[1:0]!=0) or illegal funct3 (load 011/110/111, store >=011): no dmem_req, no stall, RegWrite_WB=0 that instruction, misaligned_MEM=1 for exactly one cycle.
REQ-016 Non-memory valid instruction: passes through in one cycle, no dmem_req; valid_MEM=0 yields a bubble.
REQ-017 dmem_rdata SHALL only be sampled in the cycle dmem_ready=1 of a load.

Reset
REQ-018 On reset: state=IDLE; readData, alu_result, rd_WB = 0; MemToReg_WB, RegWrite_WB, misaligned_MEM = 0.
REQ-019 Reset in WAIT SHALL abandon the access: dmem_req=0 in the cycle after reset is sampled; a dmem_ready arriving then is ignored.
REQ-020 stall_MEM and dmem_req SHALL be 0 whenever reset is high.

Structure
REQ-021 Shared package SHALL hold funct3 load/store constants and the IDLE/WAIT state encoding.
REQ-022 Load extraction/extension SHALL be one combinational sub-module Load_Extend (inputs rdata, addr[1:0], funct3; output 32-bit value).

Verification
REQ-023 LW addr 0x100, dmem_ready=1 same cycle, rdata 0xDEADBEEF -> next cycle readData=0xDEADBEEF, RegWrite_WB=1, no stall.
REQ-024 LB addr 0x103, rdata 0x80FF_0000 -> readData=0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 -> 0xFFFF80FF.
REQ-025 SB addr 0x201 data 0x000000AB -> dmem_be=0010, dmem_wdata=0xABABABAB, dmem_we=1, dmem_addr=0x200.
REQ-026 LW with dmem_ready low 3 cycles -> stall_MEM high 3 cycles, 3 bubbles (RegWrite_WB=0), addr/be stable, then one writeback.
REQ-027 LH addr 0x101 -> no dmem_req, misaligned_MEM one-cycle pulse, RegWrite_WB=0.
REQ-028 Reset asserted in WAIT -> next cycle dmem_req=0, stall_MEM=0, all WB outputs 0, later ready ignored.
